// File: rtl/seq_detector_param_pkg.sv
// Shared definitions for the serial pattern detector: state encodings used by display
// logic, reset-time pattern defaults and the length-field width derivation.
package seq_detector_param_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_ARMED    = 2'd2
  } det_state_e;

  localparam int         DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PATTERN = 8'b0001_1010;
  localparam int         DEF_LEN     = 5;
  localparam int         DEF_CNT_W   = 8;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment yields one.
module sat_counter #(
  parameter int P_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [P_WIDTH-1:0] count
);

  logic [P_WIDTH-1:0] count_q;
  logic [P_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? P_WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + P_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern of up to P_MAX_LEN bits,
// overlapping/non-overlapping detection and a saturating match count.
module seq_detector_param
  import seq_detector_param_pkg::*;
#(
  parameter int                   P_MAX_LEN     = DEF_MAX_LEN,
  parameter logic [P_MAX_LEN-1:0] P_RST_PATTERN = P_MAX_LEN'(DEF_PATTERN),
  parameter int                   P_RST_LEN     = DEF_LEN,
  parameter int                   P_CNT_W       = DEF_CNT_W,
  parameter int                   L_LEN_W       = len_width(P_MAX_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seq_in,
  input  logic                 seq_valid,
  input  logic                 mode_overlap,
  input  logic                 pat_wr,
  input  logic [P_MAX_LEN-1:0] pat_data,
  input  logic [L_LEN_W-1:0]   pat_len,
  input  logic                 cnt_clr,
  output logic [P_MAX_LEN-1:0] LED_seq_in,
  output logic                 LED_seq_equal,
  output logic [P_CNT_W-1:0]   match_cnt,
  output logic                 armed
);

  logic [P_MAX_LEN-1:0] pat_q, pat_d;
  logic [L_LEN_W-1:0]   len_q, len_d;
  logic [P_MAX_LEN-1:0] hist_q, hist_d;
  logic [L_LEN_W-1:0]   fill_q, fill_d;
  logic                 equal_q, equal_d;
  logic                 armed_q, armed_d;

  det_state_e           state;
  logic [P_MAX_LEN-1:0] mask;
  logic [P_MAX_LEN-1:0] hist_shift;
  logic [L_LEN_W:0]     fill_inc;
  logic                 match;

  // State is implied by the length/fill registers rather than held separately.
  always_comb begin
    if (len_q == '0) begin
      state = ST_DISABLED;
    end else if (fill_q < len_q) begin
      state = ST_FILL;
    end else begin
      state = ST_ARMED;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < P_MAX_LEN; i++) begin
      mask[i] = (L_LEN_W'(i) < len_q);
    end
  end

  assign hist_shift = {hist_q[P_MAX_LEN-2:0], seq_in};
  assign fill_inc   = {1'b0, fill_q} + {{L_LEN_W{1'b0}}, 1'b1};

  // The incoming bit completes the window, so it is compared before it is registered.
  assign match = !pat_wr && seq_valid && (state != ST_DISABLED) &&
                 (fill_inc >= {1'b0, len_q}) &&
                 (((hist_shift ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    equal_d = match;
    if (pat_wr) begin
      pat_d  = pat_data;
      len_d  = (pat_len > L_LEN_W'(P_MAX_LEN)) ? L_LEN_W'(P_MAX_LEN) : pat_len;
      hist_d = '0;
      fill_d = '0;
    end else if (seq_valid && (state != ST_DISABLED)) begin
      hist_d = hist_shift;
      if (match && !mode_overlap) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_inc[L_LEN_W-1:0];
      end
    end
    armed_d = (len_d != '0) && (fill_d == len_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= P_RST_PATTERN;
      len_q   <= L_LEN_W'(P_RST_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      equal_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      equal_q <= equal_d;
      armed_q <= armed_d;
    end
  end

  sat_counter #(
    .P_WIDTH(P_CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_cnt)
  );

  assign LED_seq_in    = hist_q;
  assign LED_seq_equal = equal_q;
  assign armed         = armed_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default-parameter instance and a
// 2-bit-counter instance for saturation behaviour.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       seq_in = 1'b0, seq_valid = 1'b0, mode_overlap = 1'b1;
  logic       pat_wr = 1'b0, cnt_clr = 1'b0;
  logic [7:0] pat_data = '0;
  logic [3:0] pat_len = '0;
  logic [7:0] led_seq_in;
  logic       led_seq_equal;
  logic [7:0] match_cnt;
  logic       armed;

  logic       s2_in = 1'b0, s2_valid = 1'b0, s2_pat_wr = 1'b0, s2_clr = 1'b0;
  logic [7:0] s2_pat_data = '0;
  logic [3:0] s2_pat_len = '0;
  logic [7:0] s2_led;
  logic       s2_equal;
  logic [1:0] s2_cnt;
  logic       s2_armed;

  int errors = 0;
  int checks = 0;
  logic [31:0] pm;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .seq_valid(seq_valid),
    .mode_overlap(mode_overlap), .pat_wr(pat_wr), .pat_data(pat_data),
    .pat_len(pat_len), .cnt_clr(cnt_clr), .LED_seq_in(led_seq_in),
    .LED_seq_equal(led_seq_equal), .match_cnt(match_cnt), .armed(armed)
  );

  seq_detector_param #(.P_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seq_in(s2_in), .seq_valid(s2_valid),
    .mode_overlap(1'b1), .pat_wr(s2_pat_wr), .pat_data(s2_pat_data),
    .pat_len(s2_pat_len), .cnt_clr(s2_clr), .LED_seq_in(s2_led),
    .LED_seq_equal(s2_equal), .match_cnt(s2_cnt), .armed(s2_armed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits oldest first (bits[n-1] first); pmask[i] records the pulse after bit i.
  task automatic send(input logic [31:0] bits, input int n, output logic [31:0] pmask);
    pmask = '0;
    for (int i = 0; i < n; i++) begin
      seq_in    = bits[n-1-i];
      seq_valid = 1'b1;
      tick();
      pmask[i] = led_seq_equal;
    end
    seq_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len);
    pat_wr    = 1'b1;
    pat_data  = pat;
    pat_len   = len;
    seq_valid = 1'b0;
    tick();
    pat_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_led", {24'h0, led_seq_in}, 32'h0);
    check("rst_equal", {31'h0, led_seq_equal}, 32'h0);
    check("rst_cnt", {24'h0, match_cnt}, 32'h0);
    check("rst_armed", {31'h0, armed}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Default pattern 11010, overlap
    mode_overlap = 1'b1;
    send(32'b1101011010, 10, pm);
    check("t1_pulses", pm, 32'h210);
    check("t1_cnt", {24'h0, match_cnt}, 32'd2);
    check("t1_armed", {31'h0, armed}, 32'h1);
    check("t1_led", {24'h0, led_seq_in}, 32'h5A);

    // Pattern 101 overlap then non-overlap
    load(8'b101, 4'd3);
    check("t2_load_armed", {31'h0, armed}, 32'h0);
    check("t2_load_led", {24'h0, led_seq_in}, 32'h0);
    send(32'b10101, 5, pm);
    check("t2_ovl_pulses", pm, 32'h14);
    check("t2_ovl_cnt", {24'h0, match_cnt}, 32'd4);
    load(8'b101, 4'd3);
    mode_overlap = 1'b0;
    send(32'b10101, 5, pm);
    check("t2_novl_pulses", pm, 32'h04);
    check("t2_novl_cnt", {24'h0, match_cnt}, 32'd5);
    check("t2_novl_armed", {31'h0, armed}, 32'h0);

    // Valid gaps carrying garbage bits
    mode_overlap = 1'b1;
    load(8'b101, 4'd3);
    pm = '0;
    for (int i = 0; i < 6; i++) begin
      seq_valid = (i % 2 == 0);
      case (i)
        0: seq_in = 1'b1;
        1: seq_in = 1'b1;
        2: seq_in = 1'b0;
        3: seq_in = 1'b0;
        4: seq_in = 1'b1;
        default: seq_in = 1'b0;
      endcase
      tick();
      pm[i] = led_seq_equal;
    end
    seq_valid = 1'b0;
    check("t3_pulses", pm, 32'h10);
    check("t3_cnt", {24'h0, match_cnt}, 32'd6);
    check("t3_led", {24'h0, led_seq_in}, 32'h05);

    // Length 0 disables
    load(8'h00, 4'd0);
    pm = '0;
    for (int i = 0; i < 20; i++) begin
      seq_in    = 1'($urandom_range(0, 1));
      seq_valid = 1'b1;
      tick();
      pm[i] = led_seq_equal;
    end
    seq_valid = 1'b0;
    check("t4_dis_pulses", pm, 32'h0);
    check("t4_dis_armed", {31'h0, armed}, 32'h0);
    check("t4_dis_cnt", {24'h0, match_cnt}, 32'd6);

    // Length 12 clamps to 8
    load(8'hB7, 4'd12);
    send(32'hB7, 8, pm);
    check("t4_clamp_pulses", pm, 32'h80);
    check("t4_clamp_cnt", {24'h0, match_cnt}, 32'd7);
    check("t4_clamp_armed", {31'h0, armed}, 32'h1);
    check("t4_clamp_led", {24'h0, led_seq_in}, 32'hB7);

    // pat_wr colliding with the completing bit
    load(8'b101, 4'd3);
    send(32'b10, 2, pm);
    pat_wr    = 1'b1;
    pat_data  = 8'b101;
    pat_len   = 4'd3;
    seq_in    = 1'b1;
    seq_valid = 1'b1;
    tick();
    pat_wr    = 1'b0;
    seq_valid = 1'b0;
    check("t5_wr_equal", {31'h0, led_seq_equal}, 32'h0);
    check("t5_wr_cnt", {24'h0, match_cnt}, 32'd7);
    check("t5_wr_led", {24'h0, led_seq_in}, 32'h0);
    send(32'b101, 3, pm);
    check("t5_after_pulses", pm, 32'h4);
    check("t5_after_cnt", {24'h0, match_cnt}, 32'd8);

    // Asynchronous reset mid-pulse
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_equal", {31'h0, led_seq_equal}, 32'h0);
    check("t5_arst_cnt", {24'h0, match_cnt}, 32'h0);
    check("t5_arst_led", {24'h0, led_seq_in}, 32'h0);
    check("t5_arst_armed", {31'h0, armed}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send(32'b11010, 5, pm);
    check("t5_default_pulses", pm, 32'h10);
    check("t5_default_cnt", {24'h0, match_cnt}, 32'd1);

    // 2-bit counter saturation and clear with match
    s2_pat_wr   = 1'b1;
    s2_pat_data = 8'h01;
    s2_pat_len  = 4'd1;
    tick();
    s2_pat_wr = 1'b0;
    s2_in     = 1'b1;
    s2_valid  = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    s2_valid = 1'b0;
    check("t6_sat_cnt", {30'h0, s2_cnt}, 32'd3);
    check("t6_sat_equal", {31'h0, s2_equal}, 32'h1);
    s2_valid = 1'b1;
    s2_clr   = 1'b1;
    tick();
    s2_valid = 1'b0;
    check("t6_clr_match_cnt", {30'h0, s2_cnt}, 32'd1);
    tick();
    s2_clr = 1'b0;
    check("t6_clr_only_cnt", {30'h0, s2_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
